// File: rtl/mem_pkg.sv
// Shared types for the data-memory access controller: op encodings,
// controller states and the default memory address width.
package mem_pkg;

    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_e;

    function automatic logic is_store(op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic misaligned(op_e op, logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bus of the memory access controller.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        addr_err;

    modport master (
        output req_valid, op, addr, wdata,
        input  req_ready, resp_valid, rdata, addr_err
    );

    modport slave (
        input  req_valid, op, addr, wdata,
        output req_ready, resp_valid, rdata, addr_err
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatting: load byte/half extraction with sign or zero
// extension, and store lane merge into the previously read word.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  op_e         i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Half lane uses only lane[1], so an odd half address folds onto its lane.
    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_word[{i_lane[1], 4'b0000} +: 16];

    always_comb begin
        o_load   = 32'h0;
        o_merged = i_word;
        case (i_op)
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'h0, w_byte};
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'h0, w_half};
            OP_LW:   o_load = i_word;
            OP_SB:   o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            OP_SH:   o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            OP_SW:   o_merged = i_wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU load/store controller for a word-wide data memory.
// Define MEM_ACCESS_CTRL_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_dout
);

    state_e            r_state, w_next;
    op_e               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic              r_err;

    op_e               w_op;
    logic              w_accept;
    logic              w_range_err;
    logic              w_align_err;
    logic              w_err;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

    assign w_op        = op_e'(bus.op);
    assign w_accept    = bus.req_valid && (r_state == S_IDLE);
    assign w_range_err = (bus.addr >> ADDR_W) != 32'h0;
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
    assign w_align_err = misaligned(w_op, bus.addr[1:0]);
`else
    assign w_align_err = 1'b0;
`endif
    assign w_err       = w_range_err | w_align_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        mem_we         = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_err)              w_next = S_RESP;
                    else if (w_op == OP_SW) w_next = S_WRITE;
                    else                    w_next = S_READ;
                end
            end
            S_READ:  w_next = is_store(r_op) ? S_WRITE : S_RESP;
            S_WRITE: begin
                mem_we = 1'b1;
                w_next = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Read word is captured at the end of READ; loads format it in RESP,
    // sub-word stores merge into it during WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= OP_LB;
            r_addr  <= '0;
            r_wdata <= '0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= w_op;
                r_addr  <= bus.addr[ADDR_W-1:0];
                r_wdata <= bus.wdata;
                r_err   <= w_err;
            end
            if (r_state == S_READ) r_word <= mem_dout;
        end
    end

    mem_lane_fmt u_fmt (
        .i_op     (r_op),
        .i_lane   (r_addr[1:0]),
        .i_word   (r_word),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    assign mem_addr     = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_din      = w_merged;
    assign bus.rdata    = (r_state == S_RESP && !r_err) ? w_load : 32'h0;
    assign bus.addr_err = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a byte-level reference model predicts
// latency, response data, errors and memory writes; one process compares every cycle.
module tb_mem_access_ctrl;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din, mem_dout;
    logic          mem_we;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'h8899AABB : ((32'(i) * 32'h9E3779B1) ^ 32'hC3A50F1E);
    endfunction

    assign mem_dout = mem[mem_addr[AW-1:2]];
    always @(posedge clk) begin
        if (init_en) for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        else if (mem_we) mem[mem_addr[AW-1:2]] <= mem_din;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Expected timeline of the current transaction, in posedge counts.
    int          exp_acc = -1, exp_resp = -1, exp_we = -1, exp_idx = 0;
    logic [31:0] exp_rdata = '0, exp_din = '0, exp_maddr = '0;
    logic        exp_err = 1'b0;
    logic [31:0] cap_rdata = '0;
    logic        cap_err = 1'b0;
    logic        c_busy;

    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wd, output bit err,
                                  output logic [31:0] rd, output int lat,
                                  output int woff, output logic [31:0] nw);
        int size, off;
        logic [31:0] w, mask, v;
        w    = ref_mem[addr[AW-1:2]];
        size = (op == 0 || op == 1 || op == 5) ? 1 : (op == 2 || op == 3 || op == 6) ? 2 : 4;
        off  = int'(addr[1:0]);
        err  = (addr >> AW) != 0;
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
        if (off % size != 0) err = 1;
`else
        off = off - off % size;
`endif
        rd = '0; nw = w; woff = -1; lat = 1;
        if (!err) begin
            if (op < 5) begin
                mask = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
                v    = (w >> (8 * off)) & mask;
                if ((op == 0 || op == 2) && v[8 * size - 1]) v = v | ~mask;
                rd  = v;
                lat = 2;
            end else begin
                for (int k = 0; k < size; k++) nw[8 * (off + k) +: 8] = wd[8 * k +: 8];
                lat  = (size == 4) ? 2 : 3;
                woff = (size == 4) ? 0 : 1;
            end
        end
    endfunction

    always @(posedge clk) begin
        #2;
        c_busy = (cyc >= exp_acc) && (cyc <= exp_resp);
        chk("req_ready", bus.req_ready, !c_busy);
        chk("resp_valid", bus.resp_valid, cyc == exp_resp);
        if (cyc == exp_resp) begin
            chk("rdata", bus.rdata, exp_rdata);
            chk("addr_err", bus.addr_err, exp_err);
            chk("mem_word", mem[exp_idx], ref_mem[exp_idx]);
            cap_rdata = bus.rdata;
            cap_err   = bus.addr_err;
        end
        chk("mem_we", mem_we, cyc == exp_we);
        if (cyc == exp_we) begin
            chk("mem_din", mem_din, exp_din);
            chk("mem_addr", mem_addr, exp_maddr);
        end
    end

    // Called on a negedge; b2b means the previous transaction is in RESP now.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input bit b2b);
        bit err;
        logic [31:0] rd, nw;
        int lat, woff, a;
        model(op, addr, wd, err, rd, lat, woff, nw);
        a         = cyc + (b2b ? 2 : 1);
        exp_acc   = a;
        exp_resp  = a + lat - 1;
        exp_we    = (woff >= 0) ? a + woff : -1;
        exp_din   = nw;
        exp_rdata = rd;
        exp_err   = err;
        exp_idx   = int'(addr[AW-1:2]);
        exp_maddr = 32'(addr[AW-1:2]) << 2;
        if (woff >= 0) ref_mem[exp_idx] = nw;
        bus.req_valid = 1'b1; bus.op = op; bus.addr = addr; bus.wdata = wd;
        while (cyc < a) @(negedge clk);
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.op = 3'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
        while (cyc < exp_resp) @(negedge clk);
    endtask

    task automatic gap(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [2:0]  r_op;
    logic [31:0] r_ad;

    initial begin
        bus.req_valid = 1'b0; bus.op = '0; bus.addr = '0; bus.wdata = '0;
        init_en = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        init_en = 1'b0;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp", bus.resp_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_err", bus.addr_err, 0);
        rst_n = 1'b1;

        issue(3'd0, 32'h13, 32'h0, 0);
        chk("lit_lb_model", exp_rdata, 32'hFFFFFF88);
        chk("lit_lb_lat", 32'(exp_resp - exp_acc + 1), 2);
        chk("lit_lb", cap_rdata, 32'hFFFFFF88);
        issue(3'd1, 32'h13, 32'h0, 1);
        chk("lit_lbu", cap_rdata, 32'h00000088);
        gap(2);
        issue(3'd5, 32'h11, 32'h000000CC, 0);
        chk("lit_sb_din", exp_din, 32'h8899CCBB);
        chk("lit_sb_lat", 32'(exp_resp - exp_acc + 1), 3);
        chk("lit_sb_mem", mem[4], 32'h8899CCBB);
        issue(3'd4, 32'h10, 32'h0, 1);
        chk("lit_lw_after_sb", cap_rdata, 32'h8899CCBB);
        issue(3'd7, 32'h10, 32'h8899AABB, 1);
        issue(3'd4, 32'h10, 32'h0, 1);
        chk("lit_lw", cap_rdata, 32'h8899AABB);
        issue(3'd2, 32'h12, 32'h0, 1);
        chk("lit_lh", cap_rdata, 32'hFFFF8899);
        issue(3'd6, 32'h11, 32'h0000DEAD, 1);
`ifdef MEM_ACCESS_CTRL_ALIGN_CHECK_EN
        chk("lit_sh_err", cap_err, 1);
        chk("lit_sh_mem", mem[4], 32'h8899AABB);
`else
        chk("lit_sh_err", cap_err, 0);
        chk("lit_sh_mem", mem[4], 32'h8899DEAD);
`endif
        issue(3'd7, 32'h10, 32'h8899AABB, 1);
        issue(3'd4, 32'h400, 32'h0, 1);
        chk("lit_range_err", cap_err, 1);
        chk("lit_range_lat", 32'(exp_resp - exp_acc + 1), 1);

        // Reset in the middle of a word store.
        gap(1);
        bus.req_valid = 1'b1; bus.op = 3'd7; bus.addr = 32'h10; bus.wdata = 32'h12345678;
        exp_acc = cyc + 1; exp_resp = cyc + 2; exp_we = cyc + 1;
        exp_din = 32'h12345678; exp_maddr = 32'h10; exp_rdata = '0; exp_err = 1'b0; exp_idx = 4;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_acc = -1; exp_resp = -1; exp_we = -1;
        #1;
        chk("rstw_we", mem_we, 0);
        chk("rstw_ready", bus.req_ready, 1);
        chk("rstw_resp", bus.resp_valid, 0);
        chk("rstw_rdata", bus.rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rstw_word", mem[4], 32'h8899AABB);

        for (int t = 0; t < 300; t++) begin
            r_op = 3'($urandom);
            if ($urandom_range(0, 9) == 0) r_ad = $urandom | 32'h400;
            else r_ad = 32'($urandom_range(0, 1023));
            if (t != 0 && $urandom_range(0, 1) == 1) issue(r_op, r_ad, $urandom, 1);
            else begin
                gap($urandom_range(1, 3));
                issue(r_op, r_ad, $urandom, 0);
            end
        end
        gap(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: ADDR_W, 10, byte-address width of the attached data memory.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 op  input  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data; low byte/half used for SB/SH.
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  load result, valid with resp_valid.
REQ-011 addr_err  output  1  access rejected, valid with resp_valid.
REQ-012 mem_addr  output  ADDR_W  word-aligned byte address to memory, {addr[ADDR_W-1:2],2'b00}.
REQ-013 mem_din  output  32  write data to memory, little-endian.
REQ-014 mem_we  output  1  memory write enable; memory writes all 4 bytes on posedge.
REQ-015 mem_dout  input  32  combinational memory read data at mem_addr.

Function
REQ-016 FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-017 Accept on posedge with req_valid&&req_ready; op, addr, wdata latched.
REQ-018 Load: IDLE->READ->RESP; mem_dout latched at end of READ; resp_valid in cycle 2 after accept.
REQ-019 SW: IDLE->WRITE->RESP; mem_we=1 for exactly the WRITE cycle, mem_din=wdata.
REQ-020 SB/SH: IDLE->READ->WRITE->RESP; read word latched, addressed lane(s) replaced, merged word written; resp_valid in cycle 3.
REQ-021 Lane select: byte lane addr[1:0], half lane addr[1]; byte k = bits [8k+7:8k].
REQ-022 LB/LH sign-extend, LBU/LHU zero-extend; rdata=0 for stores and errors.
REQ-023 Error (addr[31:ADDR_W]!=0, or misalignment per REQ-034): IDLE->RESP directly, addr_err=1, no READ/WRITE, mem_we never asserted.
REQ-024 RESP lasts one cycle, then IDLE; resp_valid=1 only in RESP; new request accepted no earlier than the cycle after RESP.
REQ-025 mem_we=0 in every state but WRITE; mem_addr held stable from READ through WRITE.
REQ-026 req_valid while not ready is ignored; no queuing.

Reset
REQ-027 rst_n low forces IDLE immediately (async): req_ready=1, resp_valid=0, mem_we=0, rdata=0, addr_err=0.
REQ-028 Reset during WRITE drops mem_we before the next posedge; no write occurs; memory unchanged.
REQ-029 Reset during READ/RESP discards the transaction; no resp_valid after release.
REQ-030 First accept possible on first posedge after rst_n deasserts.

Configuration
REQ-031 Macro MEM_ACCESS_CTRL_ALIGN_CHECK_EN selects misalignment handling.
REQ-032 Defined: misaligned access raises addr_err per REQ-023.
REQ-033 Undefined: low address bits ignored (half address forced to addr[1], word to lane 0); only range errors raise addr_err.
REQ-034 Misaligned means: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.

Structure
REQ-035 Shared package mem_pkg: op encodings, FSM state enum, ADDR_W default.
REQ-036 Sub-module mem_lane_fmt (combinational): load extract/extend and store lane merge; FSM in mem_access_ctrl.

Verification (memory word 0x010 preloaded 0x8899AABB)
REQ-037 LB addr 0x013 -> resp_valid cycle 2, rdata=0xFFFFFF88, addr_err=0; LBU same -> 0x00000088.
REQ-038 SB addr 0x011, wdata 0x000000CC -> one mem_we pulse, mem_din=0x8899CCBB, resp_valid cycle 3; LW 0x010 then returns 0x8899CCBB.
REQ-039 SH addr 0x011 with macro -> resp_valid cycle 1, addr_err=1, mem_we never high; without macro -> write to half lane 0.
REQ-040 SW addr 0x010 wdata 0x12345678, rst_n low mid-WRITE -> mem_we low immediately, word stays 0x8899AABB, req_ready=1, no resp_valid.
REQ-041 req_valid held high with LW 0x010 then LH 0x012 -> second accepted cycle after first RESP; rdata 0x8899AABB then 0xFFFF8899.
REQ-042 LW addr 0x00000400 -> addr_err=1, resp_valid cycle 1, mem_we never high.
